wb_skid_stage: RTL
==================

WB_SKID_STAGE -- requirements
Module: wb_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of writeback data.
REQ-002 Parameter ADDR_W, default 5, width of register-file address.
REQ-003 Parameter ZERO_REG, default 1, register address 0 is hardwired and never written when 1.
REQ-004 Parameter DROP_NOWRITE, default 0, accepted beats with effective write-enable 0 are discarded, not stored, when 1.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  synchronous discard of all buffered beats.
REQ-008 in_valid  in  1  upstream (MEM side) beat present.
REQ-009 in_ready  out  1  stage can accept a beat this cycle.
REQ-010 in_we  in  1  beat's register-file write enable.
REQ-011 in_addr  in  ADDR_W  beat's destination register.
REQ-012 in_data  in  DATA_W  beat's writeback data.
REQ-013 out_valid  out  1  head beat present toward WB.
REQ-014 out_ready  in  1  WB consumes head beat this cycle.
REQ-015 wb_we  out  1  register-file write enable, out_valid AND head write-enable.
REQ-016 wb_addr  out  ADDR_W  head destination register.
REQ-017 wb_data  out  DATA_W  head writeback data.
REQ-018 fwd_addr  in  ADDR_W  source register queried by hazard/forwarding logic.
REQ-019 fwd_hit  out  1  a buffered beat will write fwd_addr.
REQ-020 fwd_data  out  DATA_W  data of the youngest matching buffered beat.
REQ-021 occupancy  out  2  buffered beat count, 0..2.

Function
REQ-022 Storage SHALL be two entries, MAIN (head) and SKID, each holding {we, addr, data} plus a valid bit; states EMPTY (0), ONE (MAIN valid), FULL (MAIN and SKID valid).
REQ-023 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-024 Accept = in_valid AND in_ready; pop = out_valid AND out_ready; out_valid = MAIN valid.
REQ-025 Effective write-enable SHALL be in_we AND NOT (ZERO_REG=1 AND in_addr=0), computed at accept and stored.
REQ-026 With DROP_NOWRITE=1, an accepted beat with effective write-enable 0 SHALL complete the handshake but leave state unchanged.
REQ-027 Transitions: EMPTY+accept -> ONE (MAIN<=beat); ONE+accept, no pop -> FULL (SKID<=beat); ONE+accept+pop -> ONE (MAIN<=beat); ONE+pop only -> EMPTY; FULL+pop -> ONE (MAIN<=SKID); otherwise hold.
REQ-028 Beats SHALL leave in acceptance order; latency input-to-head 1 cycle when EMPTY; no beat duplicated or lost except by flush, reset or REQ-026.
REQ-029 While out_valid=0, wb_we SHALL be 0 and wb_addr/wb_data SHALL hold last MAIN contents.
REQ-030 flush SHALL clear both valid bits next edge, discard any same-cycle accepted beat, and set in_ready=1 next cycle; rst takes priority over flush.
REQ-031 fwd_hit SHALL be combinational: 1 if a valid entry has stored we=1 and addr=fwd_addr; with ZERO_REG=1, fwd_addr=0 never hits.
REQ-032 On hit, fwd_data SHALL come from SKID if SKID matches, else MAIN; fwd_data SHALL be 0 when fwd_hit=0.
REQ-033 occupancy SHALL equal the number of valid entries after each edge.

Reset
REQ-034 On rst=1 at an edge: both valid bits 0, stored we/addr/data 0, occupancy 0, in_ready 1, out_valid 0, wb_we 0, wb_addr 0, wb_data 0, fwd_hit 0, fwd_data 0.
REQ-035 rst asserted mid-transfer SHALL drop all buffered beats with no write issued afterward.

Verification
REQ-036 Streaming: out_ready=1, beats (1,r3,0xA),(1,r4,0xB) on consecutive cycles -> wb sees r3/0xA then r4/0xB on consecutive cycles, occupancy stays 1, in_ready stays 1.
REQ-037 Backpressure: out_ready=0, send r5/0x11, r6/0x22, r7/0x33 -> third stalls (in_ready=0 after two), occupancy 2; release out_ready -> order r5,r6,r7, no loss.
REQ-038 Forwarding: FULL with MAIN r8/0x1, SKID r8/0x2, fwd_addr=8 -> fwd_hit=1, fwd_data=0x2; fwd_addr=9 -> fwd_hit=0, fwd_data=0.
REQ-039 Zero register: ZERO_REG=1, beat (1,r0,0xFF) -> wb_we=0 at head, fwd_addr=0 gives fwd_hit=0; DROP_NOWRITE=1 -> occupancy stays 0.
REQ-040 Flush: FULL, flush=1 with in_valid=1 same cycle -> next cycle occupancy 0, out_valid 0, in_ready 1, flushed beats never appear.
REQ-041 Reset: rst=1 while FULL and flush=1 -> all outputs at REQ-034 values next cycle.

Source files
------------

// File: rtl/wb_skid_stage.sv
// Two-entry writeback skid buffer between MEM and WB, with a registered in_ready.
// It also provides a forwarding lookup over the buffered beats.
module wb_skid_stage #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter bit ZERO_REG     = 1'b1,
  parameter bit DROP_NOWRITE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic                in_ready_reg;
  logic                main_we_reg, skid_we_reg;
  logic [ADDR_W-1:0]   main_addr_reg, skid_addr_reg;
  logic [DATA_W-1:0]   main_data_reg, skid_data_reg;
  logic                load_main_in, load_main_skid, load_skid;

  logic eff_we, accept, store, pop, main_valid, skid_valid;

  assign eff_we     = in_we && !(ZERO_REG && (in_addr == '0));
  assign accept     = in_valid && in_ready_reg;
  // A dropped no-write beat completes the handshake but never touches storage.
  assign store      = accept && (eff_we || !DROP_NOWRITE);
  assign main_valid = (state_reg != EMPTY);
  assign skid_valid = (state_reg == FULL);
  assign pop        = main_valid && out_ready;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (store) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (store && pop) begin
          load_main_in = 1'b1;
        end else if (store) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush leaves the stored fields alone so wb_addr/wb_data keep their last value.
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      main_we_reg   <= 1'b0;
      main_addr_reg <= '0;
      main_data_reg <= '0;
      skid_we_reg   <= 1'b0;
      skid_addr_reg <= '0;
      skid_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != FULL);
      if (load_main_in) begin
        main_we_reg   <= eff_we;
        main_addr_reg <= in_addr;
        main_data_reg <= in_data;
      end else if (load_main_skid) begin
        main_we_reg   <= skid_we_reg;
        main_addr_reg <= skid_addr_reg;
        main_data_reg <= skid_data_reg;
      end
      if (load_skid) begin
        skid_we_reg   <= eff_we;
        skid_addr_reg <= in_addr;
        skid_data_reg <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid;
  assign wb_we     = main_valid && main_we_reg;
  assign wb_addr   = main_addr_reg;
  assign wb_data   = main_data_reg;
  assign occupancy = (state_reg == FULL) ? 2'd2 : (state_reg == ONE) ? 2'd1 : 2'd0;

  logic fwd_zero, main_match, skid_match;

  assign fwd_zero   = ZERO_REG && (fwd_addr == '0);
  assign main_match = main_valid && main_we_reg && (main_addr_reg == fwd_addr) && !fwd_zero;
  assign skid_match = skid_valid && skid_we_reg && (skid_addr_reg == fwd_addr) && !fwd_zero;
  assign fwd_hit    = main_match || skid_match;
  // SKID holds the younger beat, so it wins when both entries match.
  assign fwd_data   = skid_match ? skid_data_reg : (main_match ? main_data_reg : '0);

endmodule
